// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with four run-time patterns.
// Define LED_PWM_EN to build the optional PWM brightness gate on the LED outputs.
module led_pattern_gen #(
  parameter int LED_W = 4,
  parameter int DIV   = 12000000,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [7:0]       brightness,
  output logic [LED_W-1:0] led,
  output logic             tick
);

  typedef enum logic [1:0] {
    MODE_BINARY = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ROTATE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LED_W-1:0] PAT_ONE  = LED_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [LED_W-1:0] pat;
  dir_e             dir;
  mode_e            mode_q;
  logic             step;

  mode_e            mode_in;
  logic             mode_chg;
  logic             step_now;
  logic [LED_W-1:0] pat_next;
  dir_e             dir_next;
  logic [LED_W-1:0] pat_init;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign step_now = en && (cnt == CNT_LAST);
  assign pat_init = ((mode_in == MODE_BOUNCE) || (mode_in == MODE_ROTATE)) ? PAT_ONE : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pat_next = pat;
    dir_next = dir;
    unique case (mode_q)
      MODE_BINARY: pat_next = pat + PAT_ONE;
      MODE_BOUNCE: begin
        // An empty pattern can only arise from reset/mode timing; reseed it.
        if (pat == '0) begin
          pat_next = PAT_ONE;
        end else if (dir == DIR_LEFT) begin
          if (pat[LED_W-1]) begin
            pat_next = pat >> 1;
            dir_next = DIR_RIGHT;
          end else begin
            pat_next = pat << 1;
          end
        end else begin
          if (pat[0]) begin
            pat_next = pat << 1;
            dir_next = DIR_LEFT;
          end else begin
            pat_next = pat >> 1;
          end
        end
      end
      MODE_BLINK:  pat_next = ~pat;
      MODE_ROTATE: begin
        if (pat == '0) pat_next = PAT_ONE;
        else           pat_next = {pat[LED_W-2:0], pat[LED_W-1]};
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pat    <= '0;
      dir    <= DIR_LEFT;
      mode_q <= MODE_BINARY;
      step   <= 1'b0;
    end else if (mode_chg) begin
      // A mode change wins over a coincident step and restarts the full period.
      mode_q <= mode_in;
      cnt    <= '0;
      dir    <= DIR_LEFT;
      pat    <= pat_init;
      step   <= 1'b0;
    end else if (step_now) begin
      cnt    <= '0;
      pat    <= pat_next;
      dir    <= dir_next;
      step   <= 1'b1;
    end else begin
      if (en) cnt <= cnt + CNT_ONE;
      step <= 1'b0;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm  <= '0;
      led  <= '0;
      tick <= 1'b0;
    end else begin
      pwm  <= pwm + 8'd1;
      led  <= pat & {LED_W{pwm < brightness}};
      tick <= step;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  // Output stage: led trails pat by one cycle, and tick is delayed to stay aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= '0;
      tick <= 1'b0;
    end else begin
      led  <= pat;
      tick <= step;
    end
  end
`endif

endmodule
